// File: rtl/comma_word_aligner.sv
// -----------------------------------------------------------------------------
// comma_word_aligner
//
// Finds the 10b symbol boundary in an unaligned deserializer word stream by
// hunting for K28.x commas. The previous word and the current word form a
// window, and each of the ten bit offsets yields one candidate symbol. After
// LOCK_COUNT commas at one offset the alignment is locked. It stays locked
// until LOSS_COUNT consecutive decoder code violations are reported.
//
// Parameters
//   LOCK_COUNT  commas at the same offset needed to declare lock (1..15)
//   LOSS_COUNT  consecutive code_err pulses that drop lock (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   din         unaligned 10b word, bit 0 received first
//   din_valid   din is valid this cycle; the block only advances when high
//   code_err    code violation from the downstream 8b/10b decoder
//   dout        aligned symbol {j,h,g,f,i,e,d,c,b,a}, a at bit 0
//   dout_valid  dout holds a new symbol (din_valid delayed one cycle)
//   comma_det   dout is a comma (registered together with dout)
//   align_off   current bit offset, 0..9
//   locked      high while the aligner is in LOCKED
// -----------------------------------------------------------------------------
module comma_word_aligner #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       din_valid,
  input  logic       code_err,
  output logic [9:0] dout,
  output logic       dout_valid,
  output logic       comma_det,
  output logic [3:0] align_off,
  output logic       locked
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SYNC,
    ST_LOCKED
  } state_e;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

  // A comma is recognised by its first seven bits (a..f,i). Both running
  // disparities are accepted.
  function automatic logic is_comma(input logic [9:0] sym);
    return (sym[6:0] == 7'b1111100) || (sym[6:0] == 7'b0000011);
  endfunction

  state_e     state_q,      state_d;
  logic [3:0] align_off_q,  align_off_d;
  logic [3:0] cnt_q,        cnt_d;
  logic [3:0] errcnt_q,     errcnt_d;
  logic [9:0] prev_word_q,  prev_word_d;
  logic [9:0] dout_q,       dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       comma_det_q,  comma_det_d;

  // The highest candidate (k = 9) ends at window bit 18, so din[9] never
  // takes part in a candidate in the current cycle.
  logic [18:0] window;
  logic [9:0]  comma_at;
  logic        any_comma;
  logic [3:0]  first_k;
  logic [9:0]  cur_sym;
  logic        cur_is_comma;
  logic [3:0]  cnt_inc;
  logic [3:0]  errcnt_inc;

  // Candidate extraction and the lowest-offset comma search.
  always_comb begin
    // NOTE: every variable written here gets a default first. Without the
    // default, a path that skips the assignment would infer a latch.
    window    = {din[8:0], prev_word_q};
    comma_at  = '0;
    any_comma = 1'b0;
    first_k   = '0;
    cur_sym   = '0;
    for (int k = 0; k < 10; k++) begin
      comma_at[k] = is_comma(window[k +: 10]);
      if (align_off_q == 4'(k)) begin
        cur_sym = window[k +: 10];
      end
    end
    // Scan downwards so the lowest matching offset is the one kept.
    for (int k = 9; k >= 0; k--) begin
      if (comma_at[k]) begin
        any_comma = 1'b1;
        first_k   = 4'(k);
      end
    end
    cur_is_comma = is_comma(cur_sym);
    cnt_inc      = (cnt_q    == 4'hF) ? cnt_q    : cnt_q    + 4'd1;
    errcnt_inc   = (errcnt_q == 4'hF) ? errcnt_q : errcnt_q + 4'd1;
  end

  // Next-state logic. Nothing advances on cycles without din_valid.
  always_comb begin
    state_d      = state_q;
    align_off_d  = align_off_q;
    cnt_d        = cnt_q;
    errcnt_d     = errcnt_q;
    prev_word_d  = prev_word_q;
    dout_d       = dout_q;
    comma_det_d  = comma_det_q;
    dout_valid_d = 1'b0;

    if (din_valid) begin
      prev_word_d  = din;
      // The output symbol uses the offset as it was before this cycle's update.
      dout_d       = cur_sym;
      comma_det_d  = cur_is_comma;
      dout_valid_d = 1'b1;

      unique case (state_q)
        ST_HUNT: begin
          if (any_comma) begin
            align_off_d = first_k;
            cnt_d       = 4'd1;
            state_d     = (LOCK_CNT <= 4'd1) ? ST_LOCKED : ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (cur_is_comma) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= LOCK_CNT) begin
              state_d = ST_LOCKED;
            end
          end else if (any_comma) begin
            // A comma at a different offset restarts the count there.
            align_off_d = first_k;
            cnt_d       = 4'd1;
          end
        end
        ST_LOCKED: begin
          // The offset is frozen here. Only decoder errors can drop lock, and
          // an error counts even when the symbol is also a comma.
          if (code_err) begin
            errcnt_d = errcnt_inc;
            if (errcnt_inc >= LOSS_CNT) begin
              state_d  = ST_HUNT;
              cnt_d    = '0;
              errcnt_d = '0;
            end
          end else begin
            errcnt_d = '0;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // NOTE: reset is synchronous (sampled only at the clock edge), and all state
  // uses non-blocking assignments so that every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      align_off_q  <= '0;
      cnt_q        <= '0;
      errcnt_q     <= '0;
      prev_word_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      comma_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      align_off_q  <= align_off_d;
      cnt_q        <= cnt_d;
      errcnt_q     <= errcnt_d;
      prev_word_q  <= prev_word_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      comma_det_q  <= comma_det_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign comma_det  = comma_det_q;
  assign align_off  = align_off_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: doc/comma_word_aligner.md
COMMA_WORD_ALIGNER -- requirements
Module: comma_word_aligner

Interface
REQ-001 Parameter LOCK_COUNT, default 3: number of commas at the same offset needed to declare lock (range 1..15).
REQ-002 Parameter LOSS_COUNT, default 4: number of consecutive code_err pulses that drop lock (range 1..15).
REQ-003 clk  input  1  single clock for the block; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 din  input  10  unaligned 10b word from the deserializer; bit 0 is received first.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 code_err  input  1  code-violation flag from the downstream 8b/10b decoder for the symbol it is currently decoding.
REQ-008 dout  output  10  aligned 10b symbol, in {j,h,g,f,i,e,d,c,b,a} order with a at bit 0, ready to feed the decoder.
REQ-009 dout_valid  output  1  dout holds a new symbol.
REQ-010 comma_det  output  1  dout is a comma: dout[6:0] == 7'b1111100 (RD-) or 7'b0000011 (RD+).
REQ-011 align_off  output  4  current bit offset, 0..9.
REQ-012 locked  output  1  high while in LOCKED.

Function
REQ-013 The block SHALL register prev_word <= din on every din_valid and form window[19:0] = {din, prev_word}.
REQ-014 The candidate symbol at offset k SHALL be window[k+9:k], for k = 0..9.
REQ-015 Every cycle with din_valid, the block SHALL register dout <= window[align_off+9:align_off] (offset value before any update in that cycle) and set dout_valid=1. With din_valid=0, dout_valid=0 and dout SHALL hold.
REQ-016 Latency: the symbol completed by din in cycle N SHALL appear on dout in cycle N+1.
REQ-017 The FSM SHALL have three states: HUNT, SYNC and LOCKED. It SHALL advance only on cycles with din_valid=1.
REQ-018 HUNT: if any offset holds a comma, the block SHALL load align_off with the lowest such k, set cnt=1 and go to SYNC (or directly to LOCKED if LOCK_COUNT==1). Otherwise it SHALL stay in HUNT.
REQ-019 SYNC, comma at align_off: cnt+1; the block SHALL enter LOCKED when cnt reaches LOCK_COUNT.
REQ-020 SYNC, no comma at align_off but a comma at another offset: the block SHALL reload align_off with the lowest such k and set cnt=1.
REQ-021 SYNC, no comma at any offset: no change.
REQ-022 LOCKED: commas at other offsets SHALL be ignored and align_off SHALL be frozen.
REQ-023 LOCKED, code_err: errcnt+1; when errcnt reaches LOSS_COUNT the block SHALL go to HUNT with cnt=errcnt=0.
REQ-024 LOCKED, code_err=0 on a dout_valid cycle: errcnt SHALL clear to 0.
REQ-025 code_err SHALL be ignored outside LOCKED.
REQ-026 Comma at align_off and code_err in the same cycle while LOCKED: the error SHALL be counted.
REQ-027 comma_det SHALL be registered alongside dout and be meaningful only when dout_valid=1.
REQ-028 cnt and errcnt SHALL be 4-bit saturating counters.

Reset
REQ-029 While rst=1 at a clock edge: state=HUNT, align_off=0, cnt=errcnt=0, prev_word=0, dout=0, dout_valid=0, comma_det=0, locked=0.
REQ-030 Reset asserted in any state, including mid-lock, SHALL discard alignment. The block SHALL behave identically to power-up on the first cycle after rst falls.

Verification
REQ-031 Stream K28.5 RD- (0011111010) words, shifted by 3 bits, every valid cycle -> align_off=3 after the first comma; locked=1 after the 3rd comma; dout=K28.5 with comma_det=1 on the cycle after each comma word.
REQ-032 While LOCKED, inject a comma at offset 7 -> align_off stays 3 and locked stays 1.
REQ-033 While LOCKED, pulse code_err for 3 cycles, then 1 clean cycle, then 3 more -> locked stays 1. Four consecutive code_err pulses -> locked=0 and state HUNT on the next cycle.
REQ-034 In SYNC with cnt=2, present a comma at offset 5 only -> align_off=5, cnt=1, locked=0. Then 2 more commas at offset 5 -> locked=1.
REQ-035 Toggle din_valid 1/0 during the comma stream -> counters advance only on valid cycles, and dout_valid mirrors din_valid delayed by 1 cycle.
REQ-036 Assert rst for 1 cycle while LOCKED -> all outputs 0 and align_off=0 next cycle. Relock follows after LOCK_COUNT commas.
